// File: rtl/secded_stream_decoder.sv
// -----------------------------------------------------------------------------
// secded_stream_decoder
//
// Streaming extended-Hamming (SECDED) decoder with a two-stage valid/ready
// pipeline. Stage 1 captures the received word with its syndrome and overall
// parity. Stage 2 holds the corrected word, the extracted data and the error
// flags.
//
// Codeword layout: bit 0 is overall even parity, power-of-two positions are
// Hamming parity, every other position carries data in ascending order.
//
// Optional feature macro: SECDED_ERR_CNT_EN
//   defined   : err_cnt_1 / err_cnt_2 count single / uncorrectable errors on
//               each output handshake, saturate, and clear on clear_counts.
//   undefined : err_cnt_1 / err_cnt_2 are tied to 0, clear_counts is ignored.
//
// Parameters
//   DATA_W  data bits per codeword (4..57)
//   CNT_W   width of each error counter
//
// Ports
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   in_valid      in_code holds a codeword
//   in_ready      decoder accepts in_code this cycle
//   in_code       received codeword
//   out_valid     output fields hold a decoded word
//   out_ready     downstream accepts the output this cycle
//   out_code      corrected codeword
//   out_data      data bits of out_code, lowest data position in bit 0
//   out_syndrome  syndrome of the received word
//   out_1bit_err  single-bit error detected and corrected
//   out_2bit_err  uncorrectable error detected
//   clear_counts  synchronous clear of both error counters
//   err_cnt_1     single-bit error count
//   err_cnt_2     uncorrectable error count
// -----------------------------------------------------------------------------
module secded_stream_decoder #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  // Smallest P with 2^P >= DATA_W + P + 1, written out for the legal range.
  localparam int P     = (DATA_W <= 4)  ? 3 :
                         (DATA_W <= 11) ? 4 :
                         (DATA_W <= 26) ? 5 : 6,
  localparam int CW_W  = DATA_W + P + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   out_code,
  output logic [DATA_W-1:0] out_data,
  output logic [P-1:0]      out_syndrome,
  output logic              out_1bit_err,
  output logic              out_2bit_err,
  input  logic              clear_counts,
  output logic [CNT_W-1:0]  err_cnt_1,
  output logic [CNT_W-1:0]  err_cnt_2
);

  // Codeword position carrying data bit d (skips 0 and powers of two).
  function automatic int data_pos(input int d);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int i = 1; i < 64; i++) begin
      if ((i & (i - 1)) != 0) begin
        if (cnt == d) pos = i;
        cnt++;
      end
    end
    return pos;
  endfunction

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  logic              s1_valid;
  logic [CW_W-1:0]   s1_code;
  logic [P-1:0]      s1_syn;
  logic              s1_pg;

  logic              s2_valid;
  logic [CW_W-1:0]   s2_code;
  logic [DATA_W-1:0] s2_data;
  logic [P-1:0]      s2_syn;
  logic              s2_1b;
  logic              s2_2b;

  logic              s2_adv;

  // Stage 2 can take a new word when it is empty or being drained; stage 1
  // can take one when it is empty or handing its word to stage 2. Neither
  // term looks at in_valid.
  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // ---------------------------------------------------------------------------
  // Stage 1: syndrome and overall parity of the incoming word
  // ---------------------------------------------------------------------------
  logic [P-1:0] syn_c;
  logic         pg_c;

  always_comb begin
    syn_c = '0;
    for (int k = 0; k < P; k++) begin
      for (int i = 0; i < CW_W; i++) begin
        if (((i >> k) & 1) == 1) syn_c[k] = syn_c[k] ^ in_code[i];
      end
    end
    pg_c = ^in_code;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
      s1_pg    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_code <= in_code;
        s1_syn  <= syn_c;
        s1_pg   <= pg_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: classification and correction
  // ---------------------------------------------------------------------------
  logic [CW_W-1:0]   flip_c;
  logic [CW_W-1:0]   fixed_c;
  logic [DATA_W-1:0] data_c;
  logic              one_c;
  logic              two_c;

  always_comb begin
    flip_c = '0;
    one_c  = 1'b0;
    two_c  = 1'b0;
    if (s1_pg) begin
      // Odd parity: a syndrome inside the word names the bad bit (0 means the
      // overall parity bit itself); a syndrome past the end cannot be a
      // single flip and is reported as uncorrectable.
      if (int'(s1_syn) < CW_W) begin
        one_c = 1'b1;
        for (int i = 0; i < CW_W; i++) begin
          if (int'(s1_syn) == i) flip_c[i] = 1'b1;
        end
      end else begin
        two_c = 1'b1;
      end
    end else if (s1_syn != '0) begin
      two_c = 1'b1;
    end
    fixed_c = s1_code ^ flip_c;
  end

  for (genvar d = 0; d < DATA_W; d++) begin : g_data
    assign data_c[d] = fixed_c[data_pos(d)];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_code  <= '0;
      s2_data  <= '0;
      s2_syn   <= '0;
      s2_1b    <= 1'b0;
      s2_2b    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_code <= fixed_c;
        s2_data <= data_c;
        s2_syn  <= s1_syn;
        s2_1b   <= one_c;
        s2_2b   <= two_c;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign out_code     = s2_code;
  assign out_data     = s2_data;
  assign out_syndrome = s2_syn;
  assign out_1bit_err = s2_1b;
  assign out_2bit_err = s2_2b;

  // ---------------------------------------------------------------------------
  // Error counters
  // ---------------------------------------------------------------------------
`ifdef SECDED_ERR_CNT_EN
  logic             out_hs;
  logic [CNT_W-1:0] cnt1;
  logic [CNT_W-1:0] cnt2;

  assign out_hs = s2_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (clear_counts) begin
      cnt1 <= '0;
      cnt2 <= '0;
    end else if (out_hs) begin
      if (s2_1b && (cnt1 != '1)) cnt1 <= cnt1 + CNT_W'(1);
      if (s2_2b && (cnt2 != '1)) cnt2 <= cnt2 + CNT_W'(1);
    end
  end

  assign err_cnt_1 = cnt1;
  assign err_cnt_2 = cnt2;
`else
  logic unused_clear_counts;
  assign unused_clear_counts = clear_counts;
  assign err_cnt_1 = '0;
  assign err_cnt_2 = '0;
`endif

endmodule

// File: tb/tb_secded_stream_decoder.sv
module tb_secded_stream_decoder;

  localparam int DATA_W = 8;
  localparam int P      = 4;
  localparam int CW_W   = 13;
  localparam int CNT_W  = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CW_W-1:0]   in_code = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CW_W-1:0]   out_code;
  logic [DATA_W-1:0] out_data;
  logic [P-1:0]      out_syndrome;
  logic              out_1bit_err;
  logic              out_2bit_err;
  logic              clear_counts = 1'b0;
  logic [CNT_W-1:0]  err_cnt_1;
  logic [CNT_W-1:0]  err_cnt_2;

  secded_stream_decoder #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_code      (in_code),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_code     (out_code),
    .out_data     (out_data),
    .out_syndrome (out_syndrome),
    .out_1bit_err (out_1bit_err),
    .out_2bit_err (out_2bit_err),
    .clear_counts (clear_counts),
    .err_cnt_1    (err_cnt_1),
    .err_cnt_2    (err_cnt_2)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: syndrome is the XOR of the indices of all set bits,
  // overall parity is the popcount parity.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [CW_W-1:0]   code;
    logic [DATA_W-1:0] data;
    logic [P-1:0]      syn;
    logic              one;
    logic              two;
    int                acc;
  } exp_t;

  function automatic exp_t model(input logic [CW_W-1:0] c);
    exp_t r;
    int s;
    int ones;
    int j;
    s = 0;
    ones = 0;
    for (int i = 0; i < CW_W; i++) begin
      if (c[i]) begin
        s = s ^ i;
        ones++;
      end
    end
    r.syn  = s[P-1:0];
    r.code = c;
    r.one  = 1'b0;
    r.two  = 1'b0;
    r.acc  = 0;
    if ((ones % 2) == 1) begin
      if (s < CW_W) begin
        r.code[s] = ~r.code[s];
        r.one = 1'b1;
      end else begin
        r.two = 1'b1;
      end
    end else if (s != 0) begin
      r.two = 1'b1;
    end
    r.data = '0;
    j = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ($countones(i) != 1) begin
        r.data[j] = r.code[i];
        j++;
      end
    end
    return r;
  endfunction

  function automatic logic [CW_W-1:0] encode(input logic [DATA_W-1:0] d);
    logic [CW_W-1:0] c;
    int s;
    int j;
    c = '0;
    s = 0;
    j = 0;
    for (int i = 1; i < CW_W; i++) begin
      if ($countones(i) != 1) begin
        c[i] = d[j];
        if (d[j]) s = s ^ i;
        j++;
      end
    end
    for (int k = 0; k < P; k++) begin
      if (((s >> k) & 1) == 1) c[1 << k] = 1'b1;
    end
    c[0] = ^c;
    return c;
  endfunction

  function automatic logic [CW_W-1:0] rand_code(input int mode);
    logic [CW_W-1:0] c;
    int a;
    int b;
    c = encode(DATA_W'($urandom));
    a = $urandom_range(0, CW_W - 1);
    b = (a + $urandom_range(1, CW_W - 1)) % CW_W;
    case (mode)
      1: c[a] = ~c[a];
      2: begin
        c[a] = ~c[a];
        c[b] = ~c[b];
      end
      3: c = CW_W'($urandom);
      default: ;
    endcase
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Compare process: every cycle, against the in-flight queue.
  // ---------------------------------------------------------------------------
  exp_t q[$];
  int   cyc = 0;
  int   cnt1_m = 0;
  int   cnt2_m = 0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    logic exp_ov;
    logic exp_ir;
    exp_t e;
    if (reset) begin
      q.delete();
      cnt1_m = 0;
      cnt2_m = 0;
    end else begin
      exp_ov = (q.size() > 0) && (q[0].acc <= cyc - 1);
      exp_ir = !((q.size() >= 2) && !out_ready);
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      check("in_ready", 64'(in_ready), 64'(exp_ir));
      if (exp_ov) begin
        check("out_code", 64'(out_code), 64'(q[0].code));
        check("out_data", 64'(out_data), 64'(q[0].data));
        check("out_syndrome", 64'(out_syndrome), 64'(q[0].syn));
        check("out_1bit_err", 64'(out_1bit_err), 64'(q[0].one));
        check("out_2bit_err", 64'(out_2bit_err), 64'(q[0].two));
      end
      check("err_cnt_1", 64'(err_cnt_1), 64'(cnt1_m));
      check("err_cnt_2", 64'(err_cnt_2), 64'(cnt2_m));
`ifdef SECDED_ERR_CNT_EN
      if (clear_counts) begin
        cnt1_m = 0;
        cnt2_m = 0;
      end else if (exp_ov && out_ready) begin
        if (q[0].one && cnt1_m < (1 << CNT_W) - 1) cnt1_m++;
        if (q[0].two && cnt2_m < (1 << CNT_W) - 1) cnt2_m++;
      end
`endif
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_ir) begin
        e = model(in_code);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One word alone, out_ready high: not visible after one edge, visible after two.
  task automatic send_one(input logic [CW_W-1:0] c, input logic [P-1:0] syn,
                          input logic one, input logic two, input logic [CW_W-1:0] fixed);
    in_valid = 1'b1;
    in_code  = c;
    tick();
    in_valid = 1'b0;
    @(negedge clock);
    check("lat_not_yet", 64'(out_valid), 64'd0);
    @(negedge clock);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("dir_syn", 64'(out_syndrome), 64'(syn));
    check("dir_1bit", 64'(out_1bit_err), 64'(one));
    check("dir_2bit", 64'(out_2bit_err), 64'(two));
    check("dir_code", 64'(out_code), 64'(fixed));
    tick();
  endtask

  initial begin
    exp_t e;
    int   accepted;
    logic took;

    // Hand-computed expectations pinning the model.
    e = model(13'h0000);
    check("model_0000", {e.code, e.syn, e.one, e.two}, 64'd0);
    e = model(13'h0020);
    check("model_0020", {e.code, e.syn, e.one, e.two}, {13'h0000, 4'd5, 1'b1, 1'b0});
    e = model(13'h0001);
    check("model_0001", {e.code, e.syn, e.one, e.two}, {13'h0000, 4'd0, 1'b1, 1'b0});
    e = model(13'h0006);
    check("model_0006", {e.code, e.syn, e.one, e.two}, {13'h0006, 4'd3, 1'b0, 1'b1});
    e = model(13'h0112);
    check("model_0112", {e.code, e.syn, e.one, e.two}, {13'h0112, 4'd13, 1'b0, 1'b1});
    e = model(13'h1FF8);
    check("model_data", 64'(e.data), 64'hFF);

    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_fields", {out_code, out_data, out_syndrome, out_1bit_err, out_2bit_err}, 64'd0);
    check("rst_cnts", {err_cnt_1, err_cnt_2}, 64'd0);
    tick();

    out_ready = 1'b1;
    send_one(13'h0000, 4'd0,  1'b0, 1'b0, 13'h0000);
    send_one(13'h0020, 4'd5,  1'b1, 1'b0, 13'h0000);
    send_one(13'h0001, 4'd0,  1'b1, 1'b0, 13'h0000);
    send_one(13'h0006, 4'd3,  1'b0, 1'b1, 13'h0006);
    send_one(13'h0112, 4'd13, 1'b0, 1'b1, 13'h0112);

    // Back-pressure: 4 words offered against a stalled output.
    out_ready = 1'b0;
    accepted  = 0;
    in_valid  = 1'b1;
    in_code   = rand_code(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      took = in_ready;
      if (took) accepted++;
      tick();
      if (took) in_code = rand_code(i % 4);
    end
    @(negedge clock);
    check("stall_accepted", 64'(accepted), 64'd2);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    repeat (4) tick();

    // Reset with both stages full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_code   = rand_code(0);
    tick();
    in_code   = rand_code(2);
    tick();
    in_valid  = 1'b0;
    @(negedge clock);
    check("full_before_rst", 64'(out_valid), 64'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    check("rst_mid_in_ready", 64'(in_ready), 64'd1);
    check("rst_mid_code", 64'(out_code), 64'd0);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();

`ifdef SECDED_ERR_CNT_EN
    clear_counts = 1'b1;
    tick();
    clear_counts = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_code  = rand_code(1);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    check("cnt_saturate", 64'(err_cnt_1), 64'd3);
    tick();
    clear_counts = 1'b1;
    in_valid = 1'b1;
    in_code  = rand_code(1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    clear_counts = 1'b0;
    @(negedge clock);
    check("cnt_clear_wins", 64'(err_cnt_1), 64'd0);
    tick();
`endif

    // Randomized traffic.
    in_valid = 1'b1;
    in_code  = rand_code($urandom_range(0, 3));
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      took = in_valid && in_ready;
      tick();
      out_ready    = ($urandom_range(0, 3) != 0);
      clear_counts = ($urandom_range(0, 49) == 0);
      reset        = ($urandom_range(0, 499) == 0);
      if (took || !in_valid) begin
        in_valid = ($urandom_range(0, 4) != 0);
        in_code  = rand_code($urandom_range(0, 3));
      end
    end
    reset        = 1'b0;
    clear_counts = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b1;
    repeat (6) tick();
    @(negedge clock);
    check("drain_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
